// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the set-associative write-back data cache.
package dcache_pkg;

  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_SETS        = 4;
  localparam int unsigned DEF_WAYS        = 2;
  localparam int unsigned DEF_BLOCK_BYTES = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StAllocate,
    StFlush
  } state_e;

endpackage

// File: rtl/dcache_tag_array.sv
// Per-set tag, valid, dirty and lru storage with hit detection for one indexed set.
module dcache_tag_array
  import dcache_pkg::*;
#(
  parameter int unsigned SETS  = DEF_SETS,
  parameter int unsigned WAYS  = DEF_WAYS,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned IDX_W = $clog2(SETS)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [IDX_W-1:0]            index,
  input  logic [TAG_W-1:0]            tag,
  input  logic                        op_way,
  input  logic                        touch,
  input  logic                        set_dirty,
  input  logic                        clr_dirty,
  input  logic                        fill,
  output logic [WAYS-1:0]             hit,
  output logic [WAYS-1:0][TAG_W-1:0]  way_tag,
  output logic [WAYS-1:0]             way_valid,
  output logic [WAYS-1:0]             way_dirty,
  output logic                        lru
);

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WAYS-1:0] dirty_q;
  logic [SETS-1:0]           lru_q;
  logic [WAYS-1:0][TAG_W-1:0] tag_q [SETS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      if (fill) begin
        valid_q[index][op_way] <= 1'b1;
        dirty_q[index][op_way] <= 1'b0;
      end
      if (set_dirty) dirty_q[index][op_way] <= 1'b1;
      if (clr_dirty) dirty_q[index][op_way] <= 1'b0;
      // lru names the way to evict next: the one not just used
      if (touch && WAYS == 2) lru_q[index] <= ~op_way;
    end
  end

  always_ff @(posedge clock) begin
    if (fill) tag_q[index][op_way] <= tag;
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      way_tag[w] = tag_q[index][w];
      hit[w]     = valid_q[index][w] && (tag_q[index][w] == tag);
    end
  end

  assign way_valid = valid_q[index];
  assign way_dirty = dirty_q[index];
  assign lru       = lru_q[index];

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-back, write-allocate byte data cache with line flush scanner.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned SETS        = DEF_SETS,
  parameter int unsigned WAYS        = DEF_WAYS,
  parameter int unsigned BLOCK_BYTES = DEF_BLOCK_BYTES
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic                                     read,
  input  logic                                     write,
  input  logic                                     flush,
  input  logic [ADDR_W-1:0]                        address,
  input  logic [7:0]                               writedata,
  output logic [7:0]                               readdata,
  output logic                                     busywait,
  output logic                                     mem_read,
  output logic                                     mem_write,
  output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0]    mem_address,
  output logic [8*BLOCK_BYTES-1:0]                 mem_writedata,
  input  logic [8*BLOCK_BYTES-1:0]                 mem_readdata,
  input  logic                                     mem_busywait
);

  localparam int unsigned OFF_W  = $clog2(BLOCK_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LINE_W = 8 * BLOCK_BYTES;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             access;

  assign req_tag = address[ADDR_W-1 -: TAG_W];
  assign req_idx = address[OFF_W +: IDX_W];
  assign req_off = address[OFF_W-1:0];
  assign access  = read | write;

  state_e           state_q, state_d;
  logic             victim_q, victim_d;
  logic [IDX_W-1:0] flush_set_q, flush_set_d;
  logic             flush_way_q, flush_way_d;

  logic [IDX_W-1:0]            idx;
  logic                        op_way, touch, set_dirty, clr_dirty, fill;
  logic [WAYS-1:0]             hit;
  logic [WAYS-1:0][TAG_W-1:0]  way_tag;
  logic [WAYS-1:0]             way_valid, way_dirty;
  logic                        lru;
  logic                        hit_any, hit_way, victim_sel, advance;

  logic [WAYS-1:0][LINE_W-1:0] data_q [SETS];
  logic [LINE_W-1:0]           hit_line;

  // The flush scanner borrows the single tag-array read port
  assign idx = (state_q == StFlush) ? flush_set_q : req_idx;

  dcache_tag_array #(
    .SETS  (SETS),
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_tags (
    .clock     (clock),
    .reset_n   (reset_n),
    .index     (idx),
    .tag       (req_tag),
    .op_way    (op_way),
    .touch     (touch),
    .set_dirty (set_dirty),
    .clr_dirty (clr_dirty),
    .fill      (fill),
    .hit       (hit),
    .way_tag   (way_tag),
    .way_valid (way_valid),
    .way_dirty (way_dirty),
    .lru       (lru)
  );

  assign hit_any  = |hit;
  assign hit_way  = (WAYS == 2) ? hit[WAYS-1] : 1'b0;
  assign hit_line = data_q[req_idx][hit_way];
  assign readdata = hit_line[{req_off, 3'b000} +: 8];

  always_comb begin
    if (!way_valid[0])                         victim_sel = 1'b0;
    else if (WAYS == 2 && !way_valid[WAYS-1])  victim_sel = 1'b1;
    else if (WAYS == 2)                        victim_sel = lru;
    else                                       victim_sel = 1'b0;
  end

  // Gated by reset_n so the stall drops the instant reset is applied
  assign busywait = reset_n &&
                    ((access && !(state_q == StIdle && hit_any)) || state_q == StFlush);

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    flush_set_d   = flush_set_q;
    flush_way_d   = flush_way_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = {req_tag, req_idx};
    mem_writedata = data_q[req_idx][victim_q];
    op_way        = hit_way;
    touch         = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    fill          = 1'b0;
    advance       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (hit_any) begin
            touch     = 1'b1;
            set_dirty = write;
          end else begin
            victim_d = victim_sel;
            state_d  = (way_valid[victim_sel] && way_dirty[victim_sel]) ? StWriteback
                                                                        : StAllocate;
          end
        end else if (flush) begin
          state_d     = StFlush;
          flush_set_d = '0;
          flush_way_d = 1'b0;
        end
      end
      StWriteback: begin
        mem_write   = 1'b1;
        mem_address = {way_tag[victim_q], req_idx};
        op_way      = victim_q;
        if (!mem_busywait) begin
          clr_dirty = 1'b1;
          state_d   = StAllocate;
        end
      end
      StAllocate: begin
        mem_read = 1'b1;
        op_way   = victim_q;
        if (!mem_busywait) begin
          fill    = 1'b1;
          state_d = StIdle;
        end
      end
      StFlush: begin
        op_way        = flush_way_q;
        mem_address   = {way_tag[flush_way_q], flush_set_q};
        mem_writedata = data_q[flush_set_q][flush_way_q];
        if (way_valid[flush_way_q] && way_dirty[flush_way_q]) begin
          mem_write = 1'b1;
          if (!mem_busywait) begin
            clr_dirty = 1'b1;
            advance   = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
        if (advance) begin
          if (WAYS == 2 && !flush_way_q) begin
            flush_way_d = 1'b1;
          end else begin
            flush_way_d = 1'b0;
            if (flush_set_q == IDX_W'(SETS - 1)) state_d = StIdle;
            else                                  flush_set_d = flush_set_q + IDX_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      victim_q    <= 1'b0;
      flush_set_q <= '0;
      flush_way_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      flush_set_q <= flush_set_d;
      flush_way_q <= flush_way_d;
    end
  end

  always_ff @(posedge clock) begin
    if (fill) begin
      data_q[req_idx][victim_q] <= mem_readdata;
    end else if (set_dirty) begin
      data_q[req_idx][hit_way][{req_off, 3'b000} +: 8] <= writedata;
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed scoreboard bench for dcache_assoc with a 5-cycle line memory model.
module tb_dcache_assoc;

  localparam int LAT = 5;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        read = 1'b0, write = 1'b0, flush = 1'b0;
  logic [7:0]  address = '0, writedata = '0;
  logic [7:0]  readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;

  dcache_assoc dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .read          (read),
    .write         (write),
    .flush         (flush),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 clock = ~clock;

  // Memory: byte at address a holds a ^ 0xC3 until written back
  logic [31:0] mem [64];
  int          cnt = 0;
  initial begin
    for (int b = 0; b < 64; b++)
      for (int i = 0; i < 4; i++) mem[b][i*8 +: 8] <= 8'((b * 4 + i) ^ 8'hC3);
  end
  assign mem_busywait = (mem_read | mem_write) && (cnt != LAT - 1);
  assign mem_readdata = mem[mem_address];
  always @(posedge clock) begin
    if (mem_read | mem_write) cnt <= (cnt == LAT - 1) ? 0 : cnt + 1;
    else                      cnt <= 0;
    if (mem_write && !mem_busywait) mem[mem_address] <= mem_writedata;
  end

  typedef struct packed {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } mem_txn_t;

  mem_txn_t   mem_q[$];
  logic [7:0] rd_q[$];
  int errors = 0, checks = 0;
  int mem_rd_cyc = 0, mem_wr_cyc = 0, wr_bursts = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT completes a load or a memory burst
  initial begin
    mem_txn_t   t;
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (mem_read)  mem_rd_cyc++;
      if (mem_write) mem_wr_cyc++;
      if ((mem_read || mem_write) && !mem_busywait) begin
        if (mem_write) wr_bursts++;
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_burst: actual addr=%0h wr=%0b required none",
                   mem_address, mem_write);
        end else begin
          t = mem_q.pop_front();
          chk("burst_kind", 32'(mem_write), 32'(t.wr));
          chk("burst_addr", 32'(mem_address), 32'(t.addr));
          if (t.wr) chk("burst_data", mem_writedata, t.data);
        end
      end
      if (reset_n && read && !write && !busywait) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: actual=%0h required none", readdata);
        end else begin
          e = rd_q.pop_front();
          chk("readdata", 32'(readdata), 32'(e));
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clock);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Returns cycles from issue through the completing (busywait=0) cycle
  task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        output int cyc, output logic first_busy);
    @(posedge clock);
    #1;
    read = rd; write = wr; address = a; writedata = wd;
    #1 first_busy = busywait;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      cyc++;
      if (!busywait) break;
    end
    chk("access_done", 32'(busywait), 32'd0);
    @(posedge clock);
    #1 read = 1'b0; write = 1'b0;
  endtask

  task automatic ld(input logic [7:0] a, input logic [7:0] exp, output int cyc);
    logic fb;
    rd_q.push_back(exp);
    access(1'b1, 1'b0, a, 8'h00, cyc, fb);
  endtask

  task automatic st(input logic [7:0] a, input logic [7:0] wd, output int cyc);
    logic fb;
    access(1'b0, 1'b1, a, wd, cyc, fb);
  endtask

  function automatic mem_txn_t txn(input logic wr, input logic [5:0] a, input logic [31:0] d);
    mem_txn_t t;
    t.wr = wr; t.addr = a; t.data = d;
    return t;
  endfunction

  initial begin
    int   cyc, m0, w0, b0, n;
    logic fb;

    // Reset state
    do_reset();
    chk("rst_busywait", 32'(busywait), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_valid", 32'(dut.u_tags.valid_q), 32'h00);

    // Clean miss on 0x25: block 0x09, 5 refill cycles, byte 1 returned
    mem_q.push_back(txn(1'b0, 6'h09, 32'h0));
    rd_q.push_back(8'hE6);
    m0 = mem_rd_cyc;
    access(1'b1, 1'b0, 8'h25, 8'h00, cyc, fb);
    chk("miss_busy_at_once", 32'(fb), 32'd1);
    chk("alloc_cycles", 32'(mem_rd_cyc - m0), 32'd5);
    chk("clean_miss_cycles", 32'(cyc), 32'd7);

    // Write hit then read back, no memory traffic
    m0 = mem_rd_cyc + mem_wr_cyc;
    st(8'h25, 8'hAB, cyc);
    chk("write_hit_cycles", 32'(cyc), 32'd1);
    ld(8'h25, 8'hAB, cyc);
    chk("read_hit_cycles", 32'(cyc), 32'd1);
    chk("hit_no_traffic", 32'(mem_rd_cyc + mem_wr_cyc - m0), 32'd0);
    chk("dirty_set1_way0", 32'(dut.u_tags.dirty_q), 32'h04);

    // Fill both ways of set 1, touch way0, clean eviction of way1
    do_reset();
    w0 = mem_wr_cyc;
    mem_q.push_back(txn(1'b0, 6'h09, 32'h0));
    ld(8'h25, 8'hE6, cyc);
    mem_q.push_back(txn(1'b0, 6'h19, 32'h0));
    ld(8'h65, 8'hA6, cyc);
    ld(8'h25, 8'hE6, cyc);
    chk("way0_rehit_cycles", 32'(cyc), 32'd1);
    mem_q.push_back(txn(1'b0, 6'h29, 32'h0));
    ld(8'hA5, 8'h66, cyc);
    chk("lru_evict_way1_tag", 32'(dut.u_tags.tag_q[1][1]), 32'hA);
    chk("lru_keep_way0_tag", 32'(dut.u_tags.tag_q[1][0]), 32'h2);
    chk("clean_evict_no_wb", 32'(mem_wr_cyc - w0), 32'd0);
    ld(8'h25, 8'hE6, cyc);
    chk("way0_still_hit", 32'(cyc), 32'd1);

    // Dirty eviction: write-back of block 0x19 then refill of 0x29
    do_reset();
    mem_q.push_back(txn(1'b0, 6'h09, 32'h0));
    ld(8'h25, 8'hE6, cyc);
    mem_q.push_back(txn(1'b0, 6'h19, 32'h0));
    ld(8'h65, 8'hA6, cyc);
    st(8'h65, 8'h5C, cyc);
    ld(8'h25, 8'hE6, cyc);
    mem_q.push_back(txn(1'b1, 6'h19, 32'hA4A55CA7));
    mem_q.push_back(txn(1'b0, 6'h29, 32'h0));
    ld(8'hA5, 8'h66, cyc);
    chk("dirty_miss_cycles", 32'(cyc), 32'd12);
    mem_q.push_back(txn(1'b0, 6'h19, 32'h0));
    ld(8'h65, 8'h5C, cyc);

    // Flush with dirty lines in sets 0 and 3 plus a clean line in set 1
    do_reset();
    mem_q.push_back(txn(1'b0, 6'h04, 32'h0));
    st(8'h10, 8'h11, cyc);
    mem_q.push_back(txn(1'b0, 6'h0F, 32'h0));
    st(8'h3D, 8'h22, cyc);
    mem_q.push_back(txn(1'b0, 6'h01, 32'h0));
    ld(8'h04, 8'hC7, cyc);
    chk("pre_flush_dirty", 32'(dut.u_tags.dirty_q), 32'h41);
    mem_q.push_back(txn(1'b1, 6'h04, 32'hD0D1D211));
    mem_q.push_back(txn(1'b1, 6'h0F, 32'hFCFD22FF));
    b0 = wr_bursts;
    @(posedge clock);
    #1 flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    chk("flush_busy", 32'(busywait), 32'd1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!busywait) break;
      n++;
    end
    chk("flush_scan_cycles", 32'(n), 32'd16);
    chk("flush_bursts", 32'(wr_bursts - b0), 32'd2);
    chk("flush_dirty_clear", 32'(dut.u_tags.dirty_q), 32'h00);
    chk("flush_valid_kept", 32'(dut.u_tags.valid_q), 32'h45);

    // Reset pulsed in the third refill cycle
    do_reset();
    @(posedge clock);
    #1 read = 1'b1; address = 8'h25;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0; read = 1'b0;
    #1;
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_busywait", 32'(busywait), 32'd0);
    chk("abort_valid", 32'(dut.u_tags.valid_q), 32'h00);
    @(posedge clock);
    #1 reset_n = 1'b1;
    mem_q.push_back(txn(1'b0, 6'h09, 32'h0));
    rd_q.push_back(8'hE6);
    access(1'b1, 1'b0, 8'h25, 8'h00, cyc, fb);
    chk("post_abort_miss", 32'(fb), 32'd1);
    chk("post_abort_cycles", 32'(cyc), 32'd7);

    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    chk("load_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/dcache_assoc.md
DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- ADDR_W, 8: CPU byte-address width.
- SETS, 4: number of sets; must be a power of 2 and at least 2.
- WAYS, 2: associativity; legal values are 1 and 2.
- BLOCK_BYTES, 4: bytes per block; must be a power of 2 and at least 2.

REQ-002 Derived widths SHALL be:
- OFF_W = log2(BLOCK_BYTES)
- IDX_W = log2(SETS)
- TAG_W = ADDR_W - IDX_W - OFF_W
- LINE_W = 8*BLOCK_BYTES

REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.

REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous active-low reset.
- read, in, 1: CPU load request.
- write, in, 1: CPU store request.
- flush, in, 1: single-cycle request to write back all dirty lines.
- address, in, ADDR_W: CPU byte address.
- writedata, in, 8: store byte.
- readdata, out, 8: load byte.
- busywait, out, 1: CPU stall.
- mem_read, out, 1: memory block read request.
- mem_write, out, 1: memory block write request.
- mem_address, out, ADDR_W-OFF_W: memory block address.
- mem_writedata, out, LINE_W: line being written back.
- mem_readdata, in, LINE_W: refill line.
- mem_busywait, in, 1: memory busy.

Function
REQ-005 Address split SHALL be: tag = address[ADDR_W-1 -: TAG_W], index = address[OFF_W +: IDX_W], offset = address[OFF_W-1:0].

REQ-006 Each way of each set SHALL hold data[LINE_W], tag[TAG_W], valid and dirty; each set SHALL hold one lru bit when WAYS=2.

REQ-007 Hit SHALL be defined as any way of the indexed set being valid with a matching tag. Hit, readdata and busywait SHALL be combinational from address, read, write and state.

REQ-008 Read hit in IDLE SHALL return byte[offset] of the hit way with busywait=0 in the same cycle. The next posedge SHALL set lru to point to the other way.

REQ-009 Write hit in IDLE SHALL write writedata into byte[offset] at the posedge, set dirty, update lru, and hold busywait=0.

REQ-010 Any read or write that misses SHALL assert busywait in the same cycle and keep it high until the access hits in IDLE.

REQ-011 When both read and write are high, the access SHALL be treated as a write.

REQ-012 Victim selection SHALL be the lowest-numbered invalid way if one exists, otherwise the way indicated by lru; with WAYS=1 the victim is always way 0. The victim SHALL be latched on miss entry.

REQ-013 The FSM SHALL have the states IDLE, WRITEBACK, ALLOCATE and FLUSH with these transitions:
- IDLE to WRITEBACK on a miss with a valid, dirty victim.
- IDLE to ALLOCATE on a miss otherwise.
- IDLE to FLUSH on flush, when no read or write is pending.
- WRITEBACK to ALLOCATE at the posedge where mem_busywait=0; the victim's dirty bit is cleared.
- ALLOCATE to IDLE at the posedge where mem_busywait=0; mem_readdata is written into the victim, tag is set, valid=1, dirty=0.

REQ-014 Outputs in WRITEBACK SHALL be mem_write=1, mem_address={victim tag, index}, mem_writedata=victim line. Outputs in ALLOCATE SHALL be mem_read=1, mem_address={tag, index}. All SHALL be held stable until mem_busywait falls. Otherwise mem_read=mem_write=0.

REQ-015 A clean miss SHALL cost 1 + (memory latency) cycles; a dirty miss SHALL add the write-back latency.

REQ-016 FLUSH SHALL scan sets 0 to SETS-1, way 0 before way 1, one line per cycle. Each valid dirty line SHALL be written back with the same handshake as WRITEBACK, its dirty bit cleared and valid kept. After the last line the FSM SHALL return to IDLE.

REQ-017 busywait SHALL be 1 throughout FLUSH. A flush raised while busywait=1 SHALL be ignored.

REQ-018 address, read and write SHALL be held stable by the CPU while busywait=1; the cache is not required to tolerate changes.

Reset
REQ-019 reset_n low SHALL immediately force state=IDLE, mem_read=0, mem_write=0, busywait=0 and all valid, dirty and lru bits to 0, including mid-write-back or mid-refill. Dirty data is discarded.

REQ-020 Data and tag arrays SHALL NOT be reset.

REQ-021 Release of reset_n SHALL take effect at the next posedge.

Structure
REQ-022 Package dcache_pkg SHALL hold the FSM state enum (IDLE, WRITEBACK, ALLOCATE, FLUSH) and the default parameter constants.

REQ-023 Sub-module dcache_tag_array SHALL hold per-set tag, valid, dirty and lru storage and produce the per-way hit vector. Data storage, the FSM and the flush scanner SHALL live in dcache_assoc.

Verification
REQ-024 The bench SHALL run at default parameters with memory latency 5 cycles and cover these directed scenarios:
- Reset, then read 0x25: busywait=1 at once; mem_read=1 with mem_address=0x09 for 5 cycles; next IDLE cycle returns byte 1 of the line with busywait=0.
- Write 0xAB to 0x25 (hit), then read 0x25: readdata=0xAB, no memory traffic, dirty[set1, way0]=1.
- Read 0x25 then 0x65 (same set, different tags) fill both ways; read 0x25 again; read 0xA5 evicts way1 (tag of 0x65) per lru, with no write-back because that line is clean.
- Dirty eviction: write 0x65, touch 0x25, read 0xA5: mem_write with mem_address=0x19 and the modified line, then mem_read 0x29; total stall is 12 cycles.
- Flush with two dirty lines in sets 0 and 3: exactly two mem_write bursts, in set order; all dirty=0 and valid unchanged; busywait falls after the scan.
- reset_n pulsed low in the 3rd ALLOCATE cycle: mem_read drops immediately; all lines are invalid afterwards; a subsequent read misses.
